// File: rtl/gyruss_spram_arb_if.sv
// Bus bundle for the sprite attribute RAM arbiter.
//
// It groups three sides of one single-port RAM:
//   CPU side    : CPUAD, CPURD, CPUWR, CPUDI -> arbiter; CPUDO, CPUWAIT <- arbiter
//   Sprite side : SPRQ, SPAA -> arbiter;  SPAD, SPAV <- arbiter
//   RAM side    : RMAD, RMWE, RMDI <- arbiter;  RMDO -> arbiter (1-cycle read latency)
//
// Modports:
//   slave  : the arbiter's view.
//   master : the surroundings' view (CPU decoder, sprite engine, RAM).
interface gyruss_spram_arb_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] CPUAD;
    logic          CPURD;
    logic          CPUWR;
    logic [DW-1:0] CPUDI;
    logic [DW-1:0] CPUDO;
    logic          CPUWAIT;
    logic          SPRQ;
    logic [AW-1:0] SPAA;
    logic [DW-1:0] SPAD;
    logic          SPAV;
    logic [AW-1:0] RMAD;
    logic          RMWE;
    logic [DW-1:0] RMDI;
    logic [DW-1:0] RMDO;

    modport slave (
        input  CPUAD, CPURD, CPUWR, CPUDI, SPRQ, SPAA, RMDO,
        output CPUDO, CPUWAIT, SPAD, SPAV, RMAD, RMWE, RMDI
    );

    modport master (
        output CPUAD, CPURD, CPUWR, CPUDI, SPRQ, SPAA, RMDO,
        input  CPUDO, CPUWAIT, SPAD, SPAV, RMAD, RMWE, RMDI
    );
endinterface

// File: rtl/gyruss_spram_arb.sv
// Single-port sprite attribute RAM arbiter.
//
// The sprite scan fetch has fixed timing and always owns the RAM when SPRQ is
// high. CPU accesses use the free cycles. The CPU is stalled with CPUWAIT
// until its access completes.
//
// Ports:
//   VCLKx8 : clock; all logic runs on its rising edge.
//   RESET  : synchronous, active-high reset.
//   bus    : gyruss_spram_arb_if.slave.
//            It carries the CPU bus, the sprite fetch (SPRQ/SPAA/SPAD/SPAV)
//            and the RAM port (RMAD/RMWE/RMDI/RMDO).
//   STARVE : sticky diagnostic. It sets when a CPU request has waited more
//            than STARVE_LIM cycles, and clears only on RESET.
//
// Parameters:
//   AW         : RAM address width.
//   DW         : RAM data width.
//   STARVE_LIM : CPU wait-cycle limit for STARVE.
//
// Build option SPRAM_ARB_WBUF_EN:
//   When this macro is defined, the arbiter adds a one-entry posted write
//   buffer. A CPU write to an empty buffer completes at once. The buffer
//   drains on the next cycle that has no sprite fetch, and that drain
//   outranks a new CPU access.
module gyruss_spram_arb #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_LIM = 64
) (
    input  logic              VCLKx8,
    input  logic              RESET,
    gyruss_spram_arb_if.slave bus,
    output logic              STARVE
);
    localparam int CW = $clog2(STARVE_LIM + 1);

    // The CPU access is in one of three states:
    //   CPU_IDLE  : the request is armed but has not been issued yet.
    //   CPU_RDATA : the read has been issued, and RMDO returns this cycle.
    //   CPU_DONE  : the access is complete. A held request is not reissued.
    typedef enum logic [1:0] {CPU_IDLE, CPU_RDATA, CPU_DONE} cpu_state_t;

    cpu_state_t    cpu_st_reg, cpu_st_next;
    logic          sp_tag_reg;
    logic [DW-1:0] cpudo_reg;
    logic [CW-1:0] wcnt_reg, wcnt_next;
    logic          starve_reg, starve_next;

    logic          cpu_req, cpu_is_wr, cpu_armed, cpu_done_evt, cpuwait;
    logic [AW-1:0] rmad;
    logic          rmwe;
    logic [DW-1:0] rmdi;

`ifdef SPRAM_ARB_WBUF_EN
    logic          wb_full_reg, wb_full_next, wb_capture;
    logic [AW-1:0] wb_ad_reg;
    logic [DW-1:0] wb_di_reg;
`endif

    assign cpu_req   = bus.CPURD | bus.CPUWR;
    assign cpu_is_wr = bus.CPUWR;          // RD and WR together count as a write
    assign cpu_armed = cpu_req && (cpu_st_reg == CPU_IDLE);

    always_comb begin
        cpu_st_next  = cpu_st_reg;
        cpu_done_evt = 1'b0;
        rmad         = bus.SPAA;           // idle cycles point the RAM at the sprite address
        rmwe         = 1'b0;
        rmdi         = bus.CPUDI;
`ifdef SPRAM_ARB_WBUF_EN
        wb_full_next = wb_full_reg;
        wb_capture   = 1'b0;
        // A write that finds the buffer empty never stalls.
        cpuwait      = cpu_req && (cpu_st_reg != CPU_DONE) && !(cpu_is_wr && !wb_full_reg);
        if (!bus.SPRQ) begin
            if (wb_full_reg) begin
                rmad         = wb_ad_reg;
                rmdi         = wb_di_reg;
                rmwe         = 1'b1;
                wb_full_next = 1'b0;
            end else if (cpu_armed && !cpu_is_wr) begin
                rmad        = bus.CPUAD;
                cpu_st_next = CPU_RDATA;
            end
        end
        // Capturing into the buffer does not touch the RAM.
        // It may therefore happen during a sprite fetch.
        if (cpu_armed && cpu_is_wr && !wb_full_reg) begin
            wb_capture   = 1'b1;
            wb_full_next = 1'b1;
            cpu_done_evt = 1'b1;
            cpu_st_next  = CPU_DONE;
        end
`else
        cpuwait = cpu_req && (cpu_st_reg != CPU_DONE);
        if (!bus.SPRQ && cpu_armed) begin
            rmad = bus.CPUAD;
            if (cpu_is_wr) begin
                rmwe         = 1'b1;
                cpu_done_evt = 1'b1;
                cpu_st_next  = CPU_DONE;
            end else begin
                cpu_st_next = CPU_RDATA;
            end
        end
`endif
        if (cpu_st_reg == CPU_RDATA) begin
            cpu_done_evt = 1'b1;
            cpu_st_next  = CPU_DONE;
        end
        // Dropping the request re-arms the CPU side for the following cycle.
        if (!cpu_req) begin
            cpu_st_next = CPU_IDLE;
        end

        // The wait counter saturates at STARVE_LIM.
        // One more waiting cycle at the limit means the request has waited
        // past it, so STARVE sets.
        wcnt_next   = '0;
        starve_next = starve_reg;
        if (cpuwait && !cpu_done_evt) begin
            wcnt_next = (wcnt_reg == CW'(STARVE_LIM)) ? wcnt_reg : wcnt_reg + 1'b1;
        end
        if (cpuwait && (wcnt_reg == CW'(STARVE_LIM))) begin
            starve_next = 1'b1;
        end
    end

    always_ff @(posedge VCLKx8) begin
        if (RESET) begin
            cpu_st_reg  <= CPU_IDLE;
            sp_tag_reg  <= 1'b0;
            cpudo_reg   <= '0;
            wcnt_reg    <= '0;
            starve_reg  <= 1'b0;
`ifdef SPRAM_ARB_WBUF_EN
            wb_full_reg <= 1'b0;
`endif
        end else begin
            cpu_st_reg  <= cpu_st_next;
            sp_tag_reg  <= bus.SPRQ;
            wcnt_reg    <= wcnt_next;
            starve_reg  <= starve_next;
            if (cpu_st_reg == CPU_RDATA) begin
                cpudo_reg <= bus.RMDO;
            end
`ifdef SPRAM_ARB_WBUF_EN
            wb_full_reg <= wb_full_next;
`endif
        end
    end

`ifdef SPRAM_ARB_WBUF_EN
    // The buffer payload needs no reset. It is only used while wb_full_reg
    // is set.
    always_ff @(posedge VCLKx8) begin
        if (wb_capture) begin
            wb_ad_reg <= bus.CPUAD;
            wb_di_reg <= bus.CPUDI;
        end
    end
`endif

    assign bus.RMAD    = rmad;
    assign bus.RMWE    = rmwe & ~RESET;
    assign bus.RMDI    = rmdi;
    assign bus.CPUWAIT = cpuwait;
    assign bus.CPUDO   = cpudo_reg;
    assign bus.SPAD    = bus.RMDO;         // qualified by SPAV
    assign bus.SPAV    = sp_tag_reg;
    assign STARVE      = starve_reg;
endmodule
